// File: rtl/accum_pkg.sv
// Shared types and arithmetic for the accum_ram charge accumulator.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2
    } state_t;

    // Operands arrive sign-extended from w bits, so the 64-bit sum is exact.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w,
        input bit                 sat
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat && (s > hi)) begin
            return hi;
        end
        if (sat && (s < lo)) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/dp_ram_sync.sv
// Registered-read, read-before-write memory with one read and one write port.
module dp_ram_sync #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/accum_ram.sv
// Charge accumulator memory: pipelined read-modify-write with forwarding,
// neuron-state reads with optional clear, and a whole-array clear sweep.
module accum_ram
    import accum_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [WIDTH-1:0]  acc_delta,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_clear,
    output logic              rdo_valid,
    output logic [WIDTH-1:0]  rdo_data,
    input  logic              clr_start,
    output logic              busy
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;

    logic              r_s2_valid;
    logic              r_s2_rd;
    logic              r_s2_clear;
    logic [ADDR_W-1:0] r_s2_addr;
    logic [WIDTH-1:0]  r_s2_delta;

    logic              r_fwd_valid;
    logic [ADDR_W-1:0] r_fwd_addr;
    logic [WIDTH-1:0]  r_fwd_data;

    logic              w_rd_go;
    logic              w_acc_go;
    logic [ADDR_W-1:0] w_raddr;
    logic [WIDTH-1:0]  w_ram_q;
    logic [WIDTH-1:0]  w_operand;
    logic [WIDTH-1:0]  w_sum;
    logic              w_s2_we;
    logic [WIDTH-1:0]  w_s2_data;
    logic              w_sweep_we;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [WIDTH-1:0]  w_wdata;

    assign rd_ready  = ~r_busy;
    assign acc_ready = ~r_busy & ~rd_valid;
    assign busy      = r_busy;

    assign w_rd_go  = rd_valid & ~r_busy;
    assign w_acc_go = acc_valid & acc_ready;
    assign w_raddr  = rd_valid ? rd_addr : acc_addr;

    assign w_operand = (r_fwd_valid && (r_fwd_addr == r_s2_addr))
                     ? r_fwd_data : w_ram_q;

    assign w_sum = WIDTH'(sat_add(64'($signed(w_operand)),
                                  64'($signed(r_s2_delta)),
                                  WIDTH, SATURATE != 0));

    assign w_s2_we   = r_s2_valid & (~r_s2_rd | r_s2_clear);
    assign w_s2_data = r_s2_rd ? '0 : w_sum;

    // Stage 2 is always empty while sweeping, so the write port never collides.
    assign w_sweep_we = (r_state == SWEEP);
    assign w_we       = w_s2_we | w_sweep_we;
    assign w_waddr    = w_sweep_we ? r_cnt : r_s2_addr;
    assign w_wdata    = w_sweep_we ? '0 : w_s2_data;

    assign rdo_valid = r_s2_valid & r_s2_rd;
    assign rdo_data  = rdo_valid ? w_operand : '0;

    dp_ram_sync #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_rd    <= 1'b0;
            r_s2_clear <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_delta <= '0;
        end else begin
            r_s2_valid <= w_rd_go | w_acc_go;
            r_s2_rd    <= w_rd_go;
            r_s2_clear <= w_rd_go & rd_clear;
            r_s2_addr  <= w_raddr;
            r_s2_delta <= acc_delta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= w_s2_we;
            if (w_s2_we) begin
                r_fwd_addr <= r_s2_addr;
                r_fwd_data <= w_s2_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (clr_start) begin
                        r_state <= DRAIN;
                        r_busy  <= 1'b1;
                    end
                end
                DRAIN: begin
                    r_state <= SWEEP;
                    r_cnt   <= '0;
                end
                SWEEP: begin
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= SWEEP;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_ram.sv
// Scoreboard bench for accum_ram: random and directed ops against an
// array-based reference model, plus a wrap-mode instance.
module tb_accum_ram;

    localparam int D = 256;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        acc_valid, rd_valid, rd_clear, clr_start;
    logic [7:0]  acc_addr, rd_addr;
    logic [15:0] acc_delta;
    logic        acc_ready, rd_ready, rdo_valid, busy;
    logic [15:0] rdo_data;

    logic        b_acc_valid, b_rd_valid, b_rd_clear, b_clr_start;
    logic [3:0]  b_acc_addr, b_rd_addr;
    logic [15:0] b_acc_delta;
    logic        b_acc_ready, b_rd_ready, b_rdo_valid, b_busy;
    logic [15:0] b_rdo_data;

    int checks = 0;
    int failures = 0;
    int model [D];
    int expq [$];

    always #5 clk = ~clk;

    accum_ram #(.WIDTH(16), .DEPTH(256), .SATURATE(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_addr(acc_addr), .acc_delta(acc_delta),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr(rd_addr), .rd_clear(rd_clear),
        .rdo_valid(rdo_valid), .rdo_data(rdo_data),
        .clr_start(clr_start), .busy(busy)
    );

    accum_ram #(.WIDTH(16), .DEPTH(16), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .acc_valid(b_acc_valid), .acc_ready(b_acc_ready),
        .acc_addr(b_acc_addr), .acc_delta(b_acc_delta),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
        .rd_addr(b_rd_addr), .rd_clear(b_rd_clear),
        .rdo_valid(b_rdo_valid), .rdo_data(b_rdo_data),
        .clr_start(b_clr_start), .busy(b_busy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            chk("acc_ready_rule", int'(acc_ready), int'(!busy && !rd_valid));
            chk("rd_ready_rule", int'(rd_ready), int'(!busy));
            if (rdo_valid) begin
                if (expq.size() == 0) begin
                    chk("rdo_unexpected", 1, 0);
                end else begin
                    chk("rdo_data", int'($signed(rdo_data)), expq.pop_front());
                end
            end else if (expq.size() != 0) begin
                chk("rdo_missing", 0, 1);
                void'(expq.pop_front());
            end
        end
    end

    task automatic drive_zero();
        acc_valid = 0; rd_valid = 0; rd_clear = 0; clr_start = 0;
        acc_addr = 0; rd_addr = 0; acc_delta = 0;
    endtask

    task automatic cycle(input bit av, input int aa, input int ad,
                         input bit rv, input int ra, input bit rc,
                         output bit a_ok, output bit r_ok);
        acc_valid = av; acc_addr = 8'(aa); acc_delta = 16'(ad);
        rd_valid = rv; rd_addr = 8'(ra); rd_clear = rc;
        @(negedge clk);
        a_ok = av && acc_ready;
        r_ok = rv && rd_ready;
        @(posedge clk);
        if (r_ok) begin
            expq.push_back(model[ra]);
            if (rc) model[ra] = 0;
        end
        if (a_ok) model[aa] = sat16(model[aa] + ad);
        #1;
        drive_zero();
    endtask

    task automatic do_acc(input int a, input int d);
        bit ao, ro;
        for (int t = 0; t < 100; t++) begin
            cycle(1, a, d, 0, 0, 0, ao, ro);
            if (ao) return;
        end
        chk("acc_accept_timeout", 0, 1);
    endtask

    task automatic do_rd(input int a, input bit c);
        bit ao, ro;
        for (int t = 0; t < 100; t++) begin
            cycle(0, 0, 0, 1, a, c, ao, ro);
            if (ro) return;
        end
        chk("rd_accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic busy_len(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic zero_model();
        for (int i = 0; i < D; i++) model[i] = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_acc_ready"}, int'(acc_ready), 0);
        chk({tag, "_rd_ready"}, int'(rd_ready), 0);
        chk({tag, "_rdo_valid"}, int'(rdo_valid), 0);
        chk({tag, "_rdo_data"}, int'(rdo_data), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ao, ro;
        logic [15:0] r16;
        int d;

        drive_zero();
        b_acc_valid = 0; b_rd_valid = 0; b_rd_clear = 0; b_clr_start = 0;
        b_acc_addr = 0; b_rd_addr = 0; b_acc_delta = 0;
        zero_model();

        #2 reset_n = 0;
        #1 check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1;
        busy_len(n);
        chk("post_reset_busy_cycles", n, 256);

        do_rd(0, 0);
        do_rd(128, 0);
        do_rd(255, 0);
        idle(2);

        do_acc(5, 100);
        do_acc(5, 200);
        do_acc(5, -50);
        do_rd(5, 0);
        idle(2);

        do_acc(7, 32000);
        do_acc(7, 1000);
        do_rd(7, 0);
        do_acc(7, -32768);
        do_acc(7, -32768);
        do_rd(7, 0);
        idle(2);

        do_acc(9, 42);
        do_rd(9, 1);
        do_rd(9, 0);
        cycle(1, 9, 5, 1, 9, 0, ao, ro);
        chk("both_valid_acc_stalled", int'(ao), 0);
        chk("both_valid_rd_taken", int'(ro), 1);
        cycle(1, 9, 5, 0, 0, 0, ao, ro);
        chk("stalled_acc_next_cycle", int'(ao), 1);
        do_rd(9, 1);
        do_acc(9, 7);
        do_rd(9, 0);
        idle(2);

        b_acc_valid = 1; b_acc_addr = 4'd3; b_acc_delta = 16'h7fff;
        @(negedge clk);
        chk("wrap_ready", int'(b_acc_ready), 1);
        @(posedge clk);
        #1 b_acc_delta = 16'h0001;
        @(posedge clk);
        #1 b_acc_valid = 0;
        b_rd_valid = 1; b_rd_addr = 4'd3;
        @(posedge clk);
        #1 b_rd_valid = 0;
        @(negedge clk);
        chk("wrap_rdo_valid", int'(b_rdo_valid), 1);
        chk("wrap_rdo_data", int'($signed(b_rdo_data)), -32768);
        @(posedge clk);
        #1;

        for (int i = 0; i < 600; i++) begin
            r16 = 16'($urandom);
            d = ($urandom_range(0, 3) == 0) ? int'($signed(r16))
                                           : int'($urandom_range(0, 600)) - 300;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7), d,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7),
                  $urandom_range(0, 1) == 1, ao, ro);
        end
        for (int a = 0; a < 8; a++) do_rd(a, 0);
        idle(2);

        acc_valid = 1; acc_addr = 8'd3; acc_delta = 16'd11; clr_start = 1;
        @(negedge clk);
        ao = acc_ready;
        @(posedge clk);
        if (ao) model[3] = sat16(model[3] + 11);
        #1 drive_zero();
        zero_model();
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n == 50) clr_start = 1;
            if (n == 52) clr_start = 0;
        end
        @(posedge clk);
        #1;
        chk("clr_busy_cycles", n, 257);
        chk("clr_second_ignored", int'(busy), 0);
        for (int a = 0; a < D; a++) do_rd(a, 0);
        idle(2);

        for (int i = 0; i < 20; i++) begin
            cycle(1, $urandom_range(0, 15), int'($urandom_range(0, 2000)) - 1000,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 15), 0, ao, ro);
        end
        cycle(0, 0, 0, 1, 4, 0, ao, ro);
        #1 reset_n = 0;
        expq.delete();
        #1 check_reset_outputs("midreset");
        zero_model();
        @(posedge clk);
        #1 reset_n = 1;
        busy_len(n);
        chk("midreset_busy_cycles", n, 256);
        for (int a = 0; a < 16; a++) do_rd(a, 0);
        do_rd(255, 0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
